edge_port_adapter: RTL and testbench
====================================

EDGE_PORT_ADAPTER -- requirements
Module: edge_port_adapter

Interface
REQ-001 Parameter TX_DEPTH, default 4, host-to-mesh FIFO entries (power of 2, >=2).
REQ-002 Parameter RX_DEPTH, default 4, mesh-to-host FIFO entries (power of 2, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 host_tx_data  input  32  packet from host to inject into mesh.
REQ-006 host_tx_valid  input  1  host_tx_data valid.
REQ-007 host_tx_ready  output  1  TX FIFO can accept a packet.
REQ-008 host_rx_data  output  32  packet ejected from mesh (RX FIFO head).
REQ-009 host_rx_valid  output  1  RX FIFO non-empty.
REQ-010 host_rx_ready  input  1  host consumes host_rx_data.
REQ-011 dout  output  32  packet to router boundary-port din.
REQ-012 vout  output  1  dout valid, drives router vin.
REQ-013 rin  input  1  router rout; router accepts dout.
REQ-014 din  input  32  packet from router boundary-port dout.
REQ-015 vin  input  1  router vout; din valid.
REQ-016 rout  output  1  adapter can accept din, drives router rin.

Function
REQ-017 Every transfer on every port SHALL occur exactly on a cycle where valid and ready are both 1 at the rising edge.
REQ-018 host_tx_ready SHALL equal !tx_full; a pop in the same cycle SHALL NOT make a full FIFO accept a push.
REQ-019 vout SHALL equal !tx_empty; dout SHALL be the TX FIFO head; vout and dout SHALL NOT depend combinationally on rin.
REQ-020 rout SHALL equal !rx_full; host_rx_valid SHALL equal !rx_empty; host_rx_data SHALL be the RX FIFO head.
REQ-021 Push-to-head latency SHALL be 1 cycle: a packet accepted on edge N is presented with valid high after edge N when the FIFO was empty.
REQ-022 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the count unchanged and preserve order.
REQ-023 Simultaneous push and pop on an empty FIFO: only the push takes effect; count becomes 1.
REQ-024 Read/write pointers SHALL wrap modulo depth; count SHALL be log2(depth)+1 bits and never exceed depth.
REQ-025 Packets SHALL pass unmodified, strictly FIFO order, with no drop and no duplication in either direction.
REQ-026 TX and RX paths SHALL be fully independent; backpressure on one SHALL NOT stall the other.

Reset
REQ-027 While rst=1: both FIFOs empty, pointers zero; host_tx_ready=0, vout=0, rout=0, host_rx_valid=0, dout=0, host_rx_data=0.
REQ-028 After rst deasserts, host_tx_ready=1 and rout=1 on the next cycle.
REQ-029 Reset mid-transfer SHALL discard all buffered packets; no partial state survives.

Configuration
REQ-030 Macro EDGE_PORT_STATS_EN defined: adds input stats_clr (1), outputs tx_count (16) and rx_count (16) counting mesh-side transfers (vout&&rin, vin&&rout), wrapping 0xFFFF->0, zeroed on rst or stats_clr; clear wins over a same-cycle increment.
REQ-031 Macro undefined: those ports and counters SHALL NOT exist; all other behaviour identical.

Structure
REQ-032 Shared package noc_pkg SHALL hold FLIT_W=32 and the default depth constants.
REQ-033 One sub-module sync_fifo (parameters WIDTH, DEPTH) SHALL be instantiated twice, for TX and RX.

Verification
REQ-034 Reset: hold rst 3 cycles -> all outputs 0; cycle after release host_tx_ready=1, rout=1.
REQ-035 Ordering: push 0xA0000001..0xA0000004 with rin=1 -> dout sequence identical, one per cycle, first vout one cycle after first push.
REQ-036 TX full: rin=0, push 5 packets -> 4 accepted, host_tx_ready=0 on 5th; rin=1 -> 4 packets drain in order.
REQ-037 RX backpressure: vin=1 with 6 packets, host_rx_ready=0 -> rout drops after 4; release -> 6 delivered in order, none lost.
REQ-038 Concurrent: TX and RX streams simultaneously with random ready patterns (1000 packets each) -> scoreboard match both directions.
REQ-039 Stats (EDGE_PORT_STATS_EN): 3 TX + 2 RX transfers -> tx_count=3, rx_count=2; stats_clr with a concurrent transfer -> both 0.

Source files
------------

// File: rtl/edge_port_adapter_pkg.sv
// noc_pkg: shared constants for the mesh edge-port adapter slice.
//   FLIT_W        packet width carried on every port
//   TX_DEPTH_DEF  default host-to-mesh FIFO depth
//   RX_DEPTH_DEF  default mesh-to-host FIFO depth
//   STAT_W        width of the optional transfer counters
package noc_pkg;
    localparam int FLIT_W       = 32;
    localparam int TX_DEPTH_DEF = 4;
    localparam int RX_DEPTH_DEF = 4;
    localparam int STAT_W       = 16;
endpackage

// File: rtl/edge_port_adapter_if.sv
// edge_port_adapter_if: bundles the host-side and router-side handshakes of
// the edge-port adapter.
//   slave  : the adapter's view (accepts host_tx_*, din/vin; produces
//            host_rx_*, dout/vout, rout)
//   master : the surrounding host/router view (opposite directions)
import noc_pkg::*;

interface edge_port_adapter_if;
    logic [FLIT_W-1:0] host_tx_data;
    logic              host_tx_valid;
    logic              host_tx_ready;
    logic [FLIT_W-1:0] host_rx_data;
    logic              host_rx_valid;
    logic              host_rx_ready;
    logic [FLIT_W-1:0] dout;
    logic              vout;
    logic              rin;
    logic [FLIT_W-1:0] din;
    logic              vin;
    logic              rout;

    modport slave (
        input  host_tx_data, host_tx_valid, host_rx_ready, rin, din, vin,
        output host_tx_ready, host_rx_data, host_rx_valid, dout, vout, rout
    );

    modport master (
        output host_tx_data, host_tx_valid, host_rx_ready, rin, din, vin,
        input  host_tx_ready, host_rx_data, host_rx_valid, dout, vout, rout
    );
endinterface

// File: rtl/edge_port_adapter_fifo.sv
// sync_fifo: single-clock valid/ready FIFO used for both adapter directions.
//   clk, rst              clock, synchronous active-high reset
//   in_data/valid/ready   write side; accepted when in_valid && in_ready
//   out_data/valid/ready  read side; head is presented, popped on
//                         out_valid && out_ready
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
import noc_pkg::*;

module sync_fifo #(
    parameter int WIDTH = FLIT_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             alive;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // alive holds ready low throughout reset and releases it one edge later.
    assign in_ready  = alive && !full;
    assign out_valid = !empty;
    // Head is masked when empty so stale storage never reaches the outputs.
    assign out_data  = empty ? '0 : mem[rd_ptr];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            alive  <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/edge_port_adapter.sv
// edge_port_adapter: couples a host stream to a mesh router boundary port.
//   clk, rst   clock, synchronous active-high reset
//   bus        edge_port_adapter_if.slave
//                host_tx_* -> TX FIFO -> dout/vout (router accepts on rin)
//                din/vin -> RX FIFO (rout = space) -> host_rx_*
// Optional EDGE_PORT_STATS_EN adds:
//   stats_clr  clears both counters (wins over a same-cycle increment)
//   tx_count   mesh-side TX transfers (vout && rin), wraps at 16 bits
//   rx_count   mesh-side RX transfers (vin && rout), wraps at 16 bits
import noc_pkg::*;

module edge_port_adapter #(
    parameter int TX_DEPTH = TX_DEPTH_DEF,
    parameter int RX_DEPTH = RX_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
`ifdef EDGE_PORT_STATS_EN
    input  logic                stats_clr,
    output logic [STAT_W-1:0]   tx_count,
    output logic [STAT_W-1:0]   rx_count,
`endif
    edge_port_adapter_if.slave  bus
);
    sync_fifo #(.WIDTH(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_data   (bus.host_tx_data),
        .in_valid  (bus.host_tx_valid),
        .in_ready  (bus.host_tx_ready),
        .out_data  (bus.dout),
        .out_valid (bus.vout),
        .out_ready (bus.rin)
    );

    sync_fifo #(.WIDTH(FLIT_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_data   (bus.din),
        .in_valid  (bus.vin),
        .in_ready  (bus.rout),
        .out_data  (bus.host_rx_data),
        .out_valid (bus.host_rx_valid),
        .out_ready (bus.host_rx_ready)
    );

`ifdef EDGE_PORT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            tx_count <= '0;
            rx_count <= '0;
        end else begin
            if (bus.vout && bus.rin) begin
                tx_count <= tx_count + 1'b1;
            end
            if (bus.vin && bus.rout) begin
                rx_count <= rx_count + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_edge_port_adapter.sv
// tb_edge_port_adapter: scoreboard bench for edge_port_adapter.
// Accepted packets are queued at the input handshake and compared at the
// output handshake; directed phases cover reset, ordering, full/backpressure,
// a random concurrent stream, mid-transfer reset and optional stats.
import noc_pkg::*;

module tb_edge_port_adapter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    edge_port_adapter_if bus();

`ifdef EDGE_PORT_STATS_EN
    logic              stats_clr = 1'b0;
    logic [STAT_W-1:0] tx_count;
    logic [STAT_W-1:0] rx_count;
`endif

    edge_port_adapter dut (
        .clk       (clk),
        .rst       (rst),
`ifdef EDGE_PORT_STATS_EN
        .stats_clr (stats_clr),
        .tx_count  (tx_count),
        .rx_count  (rx_count),
`endif
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;
    int tx_pops = 0;
    int rx_pops = 0;
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pop/compare before push so a same-edge push is
    // never matched against itself.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.vout && bus.rin) begin
                if (tx_q.size() == 0) check("tx_underrun", tx_q.size(), 1);
                else begin
                    check("tx_order", bus.dout, tx_q.pop_front());
                    tx_pops++;
                end
            end
            if (bus.host_tx_valid && bus.host_tx_ready) tx_q.push_back(bus.host_tx_data);
            if (bus.host_rx_valid && bus.host_rx_ready) begin
                if (rx_q.size() == 0) check("rx_underrun", rx_q.size(), 1);
                else begin
                    check("rx_order", bus.host_rx_data, rx_q.pop_front());
                    rx_pops++;
                end
            end
            if (bus.vin && bus.rout) rx_q.push_back(bus.din);
        end
    end

    initial begin
        int start;
        int sent;
        int cyc;
        int tx_sent;
        int rx_sent;
        bit tx_acc;
        bit rx_acc;
        bit rel;

        bus.host_tx_data = '0; bus.host_tx_valid = 1'b0; bus.host_rx_ready = 1'b0;
        bus.rin = 1'b0; bus.din = '0; bus.vin = 1'b0;

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        check("rst_tx_ready", bus.host_tx_ready, 0);
        check("rst_vout", bus.vout, 0);
        check("rst_rout", bus.rout, 0);
        check("rst_rx_valid", bus.host_rx_valid, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_rx_data", bus.host_rx_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        check("rel_tx_ready", bus.host_tx_ready, 1);
        check("rel_rout", bus.rout, 1);

        // Ordering: one packet per cycle straight through.
        bus.rin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.host_tx_data = 32'hA000_0001 + 32'(i);
            bus.host_tx_valid = 1'b1;
            tick();
            check("ord_vout", bus.vout, 1);
            check("ord_dout", bus.dout, 32'hA000_0001 + 32'(i));
        end
        bus.host_tx_valid = 1'b0;
        tick();
        check("ord_drained", bus.vout, 0);

        // TX full with the router stalled.
        bus.rin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.host_tx_data = 32'hC000_0000 + 32'(i);
            bus.host_tx_valid = 1'b1;
            @(negedge clk);
            check("full_ready", bus.host_tx_ready, (i < 4) ? 1 : 0);
            tick();
        end
        bus.host_tx_valid = 1'b0;
        start = tx_pops;
        bus.rin = 1'b1;
        repeat (4) tick();
        check("full_drain_cnt", tx_pops - start, 4);
        check("full_drain_vout", bus.vout, 0);

        // RX backpressure: host stalled, router offers six packets.
        bus.host_rx_ready = 1'b0;
        start = rx_pops;
        sent = 0; cyc = 0; rel = 1'b0;
        while (sent < 6 && cyc < 200) begin
            bus.din = 32'hD000_0000 + 32'(sent);
            bus.vin = 1'b1;
            @(negedge clk);
            if (bus.rout) sent++;
            else if (!rel) begin
                check("bp_accepted", sent, 4);
                rel = 1'b1;
            end
            tick();
            if (rel) bus.host_rx_ready = 1'b1;
            cyc++;
        end
        bus.vin = 1'b0;
        check("bp_timeout", (cyc < 200) ? 1 : 0, 1);
        check("bp_rout_dropped", rel, 1);
        repeat (8) tick();
        check("bp_delivered", rx_pops - start, 6);
        check("bp_rx_empty", bus.host_rx_valid, 0);

        // Concurrent random streams in both directions.
        tx_sent = 0; rx_sent = 0; cyc = 0;
        start = tx_pops;
        sent = rx_pops;
        while ((tx_sent < 1000 || rx_sent < 1000) && cyc < 30000) begin
            if (!bus.host_tx_valid && tx_sent < 1000 && $urandom_range(3) != 0) begin
                bus.host_tx_data = $urandom;
                bus.host_tx_valid = 1'b1;
            end
            if (!bus.vin && rx_sent < 1000 && $urandom_range(3) != 0) begin
                bus.din = $urandom;
                bus.vin = 1'b1;
            end
            bus.rin = 1'($urandom_range(1));
            bus.host_rx_ready = 1'($urandom_range(1));
            @(negedge clk);
            tx_acc = bus.host_tx_valid && bus.host_tx_ready;
            rx_acc = bus.vin && bus.rout;
            tick();
            cyc++;
            if (tx_acc) begin bus.host_tx_valid = 1'b0; tx_sent++; end
            if (rx_acc) begin bus.vin = 1'b0; rx_sent++; end
        end
        check("conc_timeout", (cyc < 30000) ? 1 : 0, 1);
        bus.host_tx_valid = 1'b0; bus.vin = 1'b0;
        bus.rin = 1'b1; bus.host_rx_ready = 1'b1;
        repeat (12) tick();
        check("conc_tx_cnt", tx_pops - start, 1000);
        check("conc_rx_cnt", rx_pops - sent, 1000);
        check("conc_tx_q", tx_q.size(), 0);
        check("conc_rx_q", rx_q.size(), 0);

        // Reset with packets buffered in both FIFOs.
        bus.rin = 1'b0; bus.host_rx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.host_tx_data = 32'hE000_0000 + 32'(i); bus.host_tx_valid = 1'b1;
            bus.din = 32'hF000_0000 + 32'(i); bus.vin = 1'b1;
            tick();
        end
        bus.host_tx_valid = 1'b0; bus.vin = 1'b0;
        check("mid_vout_before", bus.vout, 1);
        rst = 1'b1;
        tx_q.delete(); rx_q.delete();
        tick();
        @(negedge clk);
        check("mid_vout", bus.vout, 0);
        check("mid_rx_valid", bus.host_rx_valid, 0);
        check("mid_dout", bus.dout, 0);
        tick();
        rst = 1'b0;
        bus.rin = 1'b1; bus.host_rx_ready = 1'b1;
        repeat (2) tick();
        check("mid_no_tx_survivor", bus.vout, 0);
        check("mid_no_rx_survivor", bus.host_rx_valid, 0);
        check("mid_tx_ready", bus.host_tx_ready, 1);

`ifdef EDGE_PORT_STATS_EN
        check("st_tx_zero", 32'(tx_count), 0);
        check("st_rx_zero", 32'(rx_count), 0);
        for (int i = 0; i < 3; i++) begin
            bus.host_tx_data = 32'h5100_0000 + 32'(i); bus.host_tx_valid = 1'b1;
            bus.din = 32'h5200_0000 + 32'(i); bus.vin = (i < 2);
            tick();
        end
        bus.host_tx_valid = 1'b0; bus.vin = 1'b0;
        repeat (3) tick();
        check("st_tx_count", 32'(tx_count), 3);
        check("st_rx_count", 32'(rx_count), 2);
        bus.host_tx_data = 32'h5300_0000; bus.host_tx_valid = 1'b1;
        tick();
        bus.host_tx_valid = 1'b0;
        bus.din = 32'h5400_0000; bus.vin = 1'b1;
        stats_clr = 1'b1;
        @(negedge clk);
        check("st_clr_tx_busy", (bus.vout && bus.rin) ? 1 : 0, 1);
        check("st_clr_rx_busy", (bus.vin && bus.rout) ? 1 : 0, 1);
        tick();
        stats_clr = 1'b0; bus.vin = 1'b0;
        check("st_clr_tx", 32'(tx_count), 0);
        check("st_clr_rx", 32'(rx_count), 0);
        repeat (3) tick();
`endif

        check("end_tx_q", tx_q.size(), 0);
        check("end_rx_q", rx_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
